pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32 core.
- Drives stall (enable) and flush controls for the F/D, D/E, E/M and M/W pipeline registers.
- Resolves three hazards: load-use, taken branch/jump, and variable-latency data-memory access via a req/ready handshake.
- Holds a small FSM for memory waits with a timeout watchdog; all other hazard decode is combinational from current-cycle inputs.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_ctrl_if.sv | 23 ++
 rtl/pipe_ctrl_hazard_detect.sv | 20 ++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Data-memory access handshake between the M stage, the controller and data memory.
interface pipe_ctrl_if;

  logic memreadM;
  logic memwriteM;
  logic dmem_ready;
  logic dmem_req;

  modport master (
    input  memreadM,
    input  memwriteM,
    input  dmem_ready,
    output dmem_req
  );

  modport slave (
    output memreadM,
    output memwriteM,
    output dmem_ready,
    input  dmem_req
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use and taken-branch hazard decode from current-cycle inputs.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       memreadE,
  input  logic [4:0] rdE,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic       pcsrcE,
  output logic       lu,
  output logic       br_flush
);

  always_comb begin
    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    lu       = memreadE && (rdE != REG_ZERO) && ((rdE == rs1D) || (rdE == rs2D));
    br_flush = pcsrcE;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencing with a memory-wait FSM and timeout watchdog.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PERF_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memreadE,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             pcsrcE,
  pipe_ctrl_if.master      mem,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             err,
  output logic [1:0]       state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_memstall,
  output logic [PERF_W-1:0] perf_lu
`endif
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  pctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             memacc, memstall, lu, br_flush;

  hazard_detect u_hazard (
    .memreadE (memreadE),
    .rdE      (rdE),
    .rs1D     (rs1D),
    .rs2D     (rs2D),
    .pcsrcE   (pcsrcE),
    .lu       (lu),
    .br_flush (br_flush)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    memacc  = mem.memreadM | mem.memwriteM;
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (memacc && !mem.dmem_ready) begin
          state_d = MEM_WAIT;
          count_d = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem.dmem_ready) begin
          state_d = RUN;
          count_d = '0;
        end else if (count_q == TO_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ERR:     ;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem.dmem_req = ((state_q == RUN) && memacc) || (state_q == MEM_WAIT);
    memstall     = (mem.dmem_req && !mem.dmem_ready) || (state_q == ERR);
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    // A frozen E stage keeps pcsrcE valid, so the branch flush is simply deferred
    if (memstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (br_flush) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (lu) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
    err     = err_q;
    state_o = state_q;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_ms_q, perf_lu_q;
  logic              lu_eff;

  always_comb lu_eff = lu && !memstall && !br_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_ms_q <= '0;
      perf_lu_q <= '0;
    end else begin
      if (memstall && (perf_ms_q != '1)) perf_ms_q <= perf_ms_q + 1'b1;
      if (lu_eff && (perf_lu_q != '1))   perf_lu_q <= perf_lu_q + 1'b1;
    end
  end

  always_comb begin
    perf_memstall = perf_ms_q;
    perf_lu       = perf_lu_q;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: combinational vector table plus multi-cycle memory sequences.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned PERF_W = 32;

  // Output bundle: {dmem_req, stallF, stallD, stallE, stallM, flushD, flushE, flushW, err, state[1:0]}
  localparam logic [10:0] IDLE      = 11'b0_0000_000_0_00;
  localparam logic [10:0] LU        = 11'b0_1100_010_0_00;
  localparam logic [10:0] BR        = 11'b0_0000_110_0_00;
  localparam logic [10:0] REQ       = 11'b1_0000_000_0_00;
  localparam logic [10:0] REQ_LU    = 11'b1_1100_010_0_00;
  localparam logic [10:0] STALL_RUN = 11'b1_1111_001_0_00;
  localparam logic [10:0] STALL_MW  = 11'b1_1111_001_0_01;
  localparam logic [10:0] REL_MW    = 11'b1_0000_000_0_01;
  localparam logic [10:0] REL_MW_BR = 11'b1_0000_110_0_01;
  localparam logic [10:0] IN_ERR    = 11'b0_1111_001_1_10;

  logic       clk, rst;
  logic       memreadE, pcsrcE;
  logic [4:0] rdE, rs1D, rs2D;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, err;
  logic [1:0] state_o;
  logic [10:0] outs;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_memstall, perf_lu;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl_if mem_if ();

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(8), .PERF_W(PERF_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .memreadE (memreadE),
    .rdE      (rdE),
    .rs1D     (rs1D),
    .rs2D     (rs2D),
    .pcsrcE   (pcsrcE),
    .mem      (mem_if.master),
    .stallF   (stallF),
    .stallD   (stallD),
    .stallE   (stallE),
    .stallM   (stallM),
    .flushD   (flushD),
    .flushE   (flushE),
    .flushW   (flushW),
    .err      (err),
    .state_o  (state_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_memstall (perf_memstall),
    .perf_lu       (perf_lu)
`endif
  );

  assign outs = {mem_if.dmem_req, stallF, stallD, stallE, stallM,
                 flushD, flushE, flushW, err, state_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        memreadE;
    logic [4:0]  rdE;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic        pcsrcE;
    logic        memreadM;
    logic        memwriteM;
    logic        dmem_ready;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic set_in(input logic mE, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic pc, input logic mR,
                        input logic mW, input logic rdy);
    memreadE          = mE;
    rdE               = rd;
    rs1D              = r1;
    rs2D              = r2;
    pcsrcE            = pc;
    mem_if.memreadM   = mR;
    mem_if.memwriteM  = mW;
    mem_if.dmem_ready = rdy;
  endtask

  task automatic chk(input string nm, input logic [10:0] exp);
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, outs, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Drive at the falling edge, sample 2 time units later, well before the rising edge
  task automatic step(input string nm, input logic mE, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic pc,
                      input logic mR, input logic mW, input logic rdy,
                      input logic [10:0] exp);
    @(negedge clk);
    set_in(mE, rd, r1, r2, pc, mR, mW, rdy);
    #2;
    chk(nm, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
    vecs[1]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LU};
    vecs[2]  = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, LU};
    vecs[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
    vecs[4]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
    vecs[5]  = '{1'b1, 5'd5, 5'd6, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
    vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, BR};
    vecs[7]  = '{1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, BR};
    vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, REQ};
    vecs[9]  = '{1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, REQ_LU};
    vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, IDLE};

    rst = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("reset", IDLE);

    for (int i = 0; i < 11; i++) begin
      step($sformatf("vec%0d", i), vecs[i].memreadE, vecs[i].rdE, vecs[i].rs1D,
           vecs[i].rs2D, vecs[i].pcsrcE, vecs[i].memreadM, vecs[i].memwriteM,
           vecs[i].dmem_ready, vecs[i].exp);
    end
    step("post_table_idle", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
`ifdef PIPE_CTRL_PERF_EN
    chk32("perf_lu_table", perf_lu, 32'd3);
    chk32("perf_ms_table", perf_memstall, 32'd0);
`endif

    // 3-cycle load: three stalled cycles, release on the fourth
    step("load_c0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, STALL_RUN);
    step("load_c1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, STALL_MW);
    step("load_c2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, STALL_MW);
    step("load_rel", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, REL_MW);
    step("load_done", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

    // Branch (with a coincident load-use) held across a memory wait
    step("brw_c0", 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, STALL_RUN);
    step("brw_c1", 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, STALL_MW);
    step("brw_rel", 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, REL_MW_BR);
    step("brw_done", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

    // Timeout watchdog with TIMEOUT=4, starting from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step("to_c0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, STALL_RUN);
    step("to_c1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, STALL_MW);
    step("to_c2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, STALL_MW);
    step("to_c3", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, STALL_MW);
    step("to_err", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, IN_ERR);
`ifdef PIPE_CTRL_PERF_EN
    chk32("perf_ms_err4", perf_memstall, 32'd4);
`endif
    step("err_rdy_pulse", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, IN_ERR);
`ifdef PIPE_CTRL_PERF_EN
    chk32("perf_ms_err5", perf_memstall, 32'd5);
`endif
    step("err_hold", 1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, IN_ERR);
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("err_cleared", IDLE);
`ifdef PIPE_CTRL_PERF_EN
    chk32("perf_ms_reset", perf_memstall, 32'd0);
    chk32("perf_lu_reset", perf_lu, 32'd0);
`endif
    step("after_reset_lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LU);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
